debayer_line_ctrl: RTL and testbench

Frame-level sequencer for the 4-line Bayer line buffer and debayer datapath (raw2rgb).
- Watches CSI line payload activity and frame markers.
- Holds the datapath read side in reset (rgb_valid low) until PRIME_LINES lines are buffered, then enables it and tracks written versus read lines.
- Re-aligns the datapath's 2-cycle output latency into pix_valid/line_start/frame_sync for the downstream RGB sink, and flags line-buffer overrun.

---
 rtl/debayer_pkg.sv | 20 ++
 rtl/debayer_valid_align.sv | 50 +++++
 rtl/debayer_line_ctrl.sv | 123 ++++++++++++
 tb/tb_debayer_line_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debayer_pkg.sv
// Shared types and constants for the debayer line sequencer.
// Provides the FSM state enum, line-buffer depth and counter-width helper.
package debayer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        DRAIN,
        ABORT
    } state_t;

    localparam int NUM_LINE_BUF = 4;

    // Width of a counter that must hold 0..n inclusive.
    function automatic int lcw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debayer_valid_align.sv
// Re-aligns datapath read activity to its output latency.
// Ports: clk, rst, rgb_valid (sync clear when low), reading, arm (enter RUN),
//        pix_valid, line_start, frame_sync, empty (delay line holds no 1s).
module debayer_valid_align
    import debayer_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rgb_valid,
    input  logic reading,
    input  logic arm,
    output logic pix_valid,
    output logic line_start,
    output logic frame_sync,
    output logic empty
);

    logic [LAT-1:0] sr;
    logic           pix_d1;
    logic           armed;

    always_ff @(posedge clk) begin
        if (rst || !rgb_valid) begin
            sr     <= '0;
            pix_d1 <= 1'b0;
        end else begin
            // Shift toward the MSB; the LSB takes the newest reading bit.
            sr     <= LAT'({sr, reading});
            pix_d1 <= sr[LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed <= 1'b0;
        end else if (arm) begin
            armed <= 1'b1;
        end else if (frame_sync) begin
            armed <= 1'b0;
        end
    end

    assign pix_valid  = sr[LAT-1];
    assign line_start = pix_valid & ~pix_d1;
    assign frame_sync = line_start & armed;
    assign empty      = (sr == '0);

endmodule

// File: rtl/debayer_line_ctrl.sv
// Frame sequencer for the 4-line Bayer buffer and debayer datapath.
// Ports: frame_start/frame_end/data_valid/reading in; rgb_valid, pix_valid,
//        line_start, frame_sync, wr/rd_line_cnt, overrun, busy out.
module debayer_line_ctrl
    import debayer_pkg::*;
#(
    parameter int LINE_LENGTH = 640,
    parameter int NUM_LINES   = 480,
    parameter int PRIME_LINES = 2,
    parameter int LAT         = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic                       frame_end,
    input  logic                       data_valid,
    input  logic                       reading,
    output logic                       rgb_valid,
    output logic                       pix_valid,
    output logic                       line_start,
    output logic                       frame_sync,
    output logic [lcw(NUM_LINES)-1:0]  wr_line_cnt,
    output logic [lcw(NUM_LINES)-1:0]  rd_line_cnt,
    output logic                       overrun,
    output logic                       busy
);

    localparam int LCW = lcw(NUM_LINES);
    localparam logic [LCW-1:0] MAXL     = LCW'(NUM_LINES);
    localparam logic [LCW-1:0] PRIME_M1 = LCW'(PRIME_LINES - 1);
    localparam logic [LCW-1:0] BUF_MAX  = LCW'(NUM_LINE_BUF - 1);

    if (PRIME_LINES < 1 || PRIME_LINES > 3 || LINE_LENGTH < 1 || LAT < 1)
    begin : g_param_check
        $error("debayer_line_ctrl: illegal parameter set");
    end

    state_t         state;
    state_t         state_next;
    logic           dv_d;
    logic           rd_d;
    logic           clr;
    logic           wr_inc;
    logic           rd_inc;
    logic           arm;
    logic           align_empty;
    logic [LCW-1:0] diff;

    // frame_start clears in the same cycle, so a coincident edge is lost.
    assign clr    = frame_start | (state == ABORT);
    assign wr_inc = dv_d & ~data_valid & (wr_line_cnt != MAXL);
    assign rd_inc = rd_d & ~reading & (rd_line_cnt != MAXL);
    assign diff   = wr_line_cnt - rd_line_cnt;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (frame_start) state_next = PRIME;
            end
            PRIME: begin
                if (frame_start) state_next = ABORT;
                else if (frame_end) state_next = IDLE;
                else if (wr_inc && wr_line_cnt == PRIME_M1) state_next = RUN;
            end
            RUN: begin
                if (frame_start) state_next = ABORT;
                else if (frame_end || rd_line_cnt == MAXL) state_next = DRAIN;
            end
            DRAIN: begin
                if (frame_start) state_next = ABORT;
                else if (!reading && align_empty) state_next = IDLE;
            end
            ABORT: begin
                state_next = PRIME;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dv_d        <= 1'b0;
            rd_d        <= 1'b0;
            wr_line_cnt <= '0;
            rd_line_cnt <= '0;
            overrun     <= 1'b0;
        end else begin
            state <= state_next;
            dv_d  <= data_valid;
            rd_d  <= reading;
            if (clr) begin
                wr_line_cnt <= '0;
                rd_line_cnt <= '0;
            end else begin
                if (wr_inc) wr_line_cnt <= wr_line_cnt + LCW'(1);
                if (rd_inc) rd_line_cnt <= rd_line_cnt + LCW'(1);
            end
            if ((state == RUN || state == DRAIN) && diff > BUF_MAX)
                overrun <= 1'b1;
        end
    end

    assign rgb_valid = (state == RUN) || (state == DRAIN);
    assign busy      = (state != IDLE);
    assign arm       = (state == PRIME) && (state_next == RUN);

    debayer_valid_align #(
        .LAT (LAT)
    ) u_align (
        .clk        (clk),
        .rst        (rst),
        .rgb_valid  (rgb_valid),
        .reading    (reading),
        .arm        (arm),
        .pix_valid  (pix_valid),
        .line_start (line_start),
        .frame_sync (frame_sync),
        .empty      (align_empty)
    );

endmodule

// File: tb/tb_debayer_line_ctrl.sv
// Self-checking bench for debayer_line_ctrl.
// Scenario tasks drive frames; pix_valid timing goes through a scoreboard.
module tb_debayer_line_ctrl;

    localparam int LL  = 8;
    localparam int NL  = 4;
    localparam int PL  = 2;
    localparam int LAT = 2;
    localparam int LCW = $clog2(NL + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic frame_end = 1'b0;
    logic data_valid = 1'b0;
    logic reading = 1'b0;
    logic rgb_valid, pix_valid, line_start, frame_sync, overrun, busy;
    logic [LCW-1:0] wr_line_cnt, rd_line_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall = 0;
    int exp_q[$];
    int obs_q[$];
    int n_ls = 0;
    int n_fs = 0;
    int n_rise = 0;
    int rise_cyc = -1;
    logic rgb_prev = 1'b0;

    debayer_line_ctrl #(
        .LINE_LENGTH (LL),
        .NUM_LINES   (NL),
        .PRIME_LINES (PL),
        .LAT         (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .data_valid  (data_valid),
        .reading     (reading),
        .rgb_valid   (rgb_valid),
        .pix_valid   (pix_valid),
        .line_start  (line_start),
        .frame_sync  (frame_sync),
        .wr_line_cnt (wr_line_cnt),
        .rd_line_cnt (rd_line_cnt),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pix_valid) obs_q.push_back(cyc);
        if (line_start) n_ls <= n_ls + 1;
        if (frame_sync) n_fs <= n_fs + 1;
        if (rgb_valid && !rgb_prev) begin
            n_rise   <= n_rise + 1;
            rise_cyc <= cyc;
        end
        rgb_prev <= rgb_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic fs, input logic fe);
        frame_start = fs;
        frame_end   = fe;
        tick();
        frame_start = 1'b0;
        frame_end   = 1'b0;
    endtask

    // One line slot: LL active cycles, then 4 idle cycles.
    task automatic line(input bit wr, input bit rd);
        data_valid = wr;
        reading    = rd;
        if (rd) for (int i = 0; i < LL; i++) exp_q.push_back(cyc + i + LAT);
        repeat (LL) tick();
        data_valid = 1'b0;
        reading    = 1'b0;
        last_fall  = cyc;
        repeat (4) tick();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_timeout busy=%b want 0", tag, busy);
        end
    endtask

    task automatic run_frame(input bit send_fs, input string tag);
        int ls0, fs0;
        ls0 = n_ls;
        fs0 = n_fs;
        exp_q.delete();
        obs_q.delete();
        if (send_fs) pulse(1'b1, 1'b0);
        line(1, 0);
        line(1, 0);
        checks++;
        if (rise_cyc !== last_fall + 1) begin
            errors++;
            $display("FAIL %s rgb_rise cyc=%0d want %0d",
                     tag, rise_cyc, last_fall + 1);
        end
        line(1, 1);
        line(1, 1);
        line(0, 1);
        line(0, 1);
        wait_idle(tag);
        checks++;
        if ({wr_line_cnt, rd_line_cnt} !== {LCW'(NL), LCW'(NL)}) begin
            errors++;
            $display("FAIL %s counts wr=%0d rd=%0d want %0d/%0d",
                     tag, wr_line_cnt, rd_line_cnt, NL, NL);
        end
        checks++;
        if (n_ls - ls0 !== 4) begin
            errors++;
            $display("FAIL %s line_start n=%0d want 4", tag, n_ls - ls0);
        end
        checks++;
        if (n_fs - fs0 !== 1) begin
            errors++;
            $display("FAIL %s frame_sync n=%0d want 1", tag, n_fs - fs0);
        end
        checks++;
        if ({overrun, rgb_valid} !== 2'b00) begin
            errors++;
            $display("FAIL %s ovr_rgb got=%b want 00", tag, {overrun, rgb_valid});
        end
        while (exp_q.size() > 0) begin
            int e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s pix_cycle got=%0d want %0d", tag, o, e);
            end
        end
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("FAIL %s pix_extra n=%0d want 0", tag, obs_q.size());
            obs_q.delete();
        end
        pulse(1'b0, 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s fe_in_idle busy=%b want 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({rgb_valid, pix_valid, line_start, frame_sync, overrun, busy,
             wr_line_cnt, rd_line_cnt} !== '0) begin
            errors++;
            $display("FAIL reset outputs got=%b want 0",
                     {rgb_valid, pix_valid, line_start, frame_sync, overrun,
                      busy, wr_line_cnt, rd_line_cnt});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_frame();
        run_frame(1'b1, "frame");
    endtask

    task automatic test_reset_mid_run();
        pulse(1'b1, 1'b0);
        line(1, 0);
        line(1, 0);
        data_valid = 1'b1;
        tick();
        rst = 1'b1;
        data_valid = 1'b0;
        tick();
        checks++;
        if ({rgb_valid, pix_valid, line_start, frame_sync, overrun, busy,
             wr_line_cnt, rd_line_cnt} !== '0) begin
            errors++;
            $display("FAIL mid_reset outputs got=%b want 0",
                     {rgb_valid, pix_valid, line_start, frame_sync, overrun,
                      busy, wr_line_cnt, rd_line_cnt});
        end
        rst = 1'b0;
        tick();
        run_frame(1'b1, "after_reset");
    endtask

    task automatic test_abort();
        pulse(1'b1, 1'b0);
        line(1, 0);
        line(1, 0);
        line(1, 1);
        checks++;
        if (rgb_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort pre_rgb got=%b want 1", rgb_valid);
        end
        pulse(1'b1, 1'b0);
        checks++;
        if ({rgb_valid, busy, wr_line_cnt, rd_line_cnt} !==
            {1'b0, 1'b1, LCW'(0), LCW'(0)}) begin
            errors++;
            $display("FAIL abort state rgb=%b busy=%b wr=%0d rd=%0d want 0 1 0 0",
                     rgb_valid, busy, wr_line_cnt, rd_line_cnt);
        end
        tick();
        checks++;
        if ({rgb_valid, busy} !== 2'b01) begin
            errors++;
            $display("FAIL abort prime rgb_busy=%b want 01", {rgb_valid, busy});
        end
        run_frame(1'b0, "post_abort");
    endtask

    task automatic test_overrun();
        test_reset();
        pulse(1'b1, 1'b0);
        line(1, 0);
        line(1, 0);
        line(1, 0);
        checks++;
        if ({overrun, wr_line_cnt} !== {1'b0, LCW'(3)}) begin
            errors++;
            $display("FAIL ovr_at3 ovr=%b wr=%0d want 0 3", overrun, wr_line_cnt);
        end
        line(1, 0);
        checks++;
        if ({overrun, wr_line_cnt} !== {1'b1, LCW'(4)}) begin
            errors++;
            $display("FAIL ovr_at4 ovr=%b wr=%0d want 1 4", overrun, wr_line_cnt);
        end
        line(1, 0);
        checks++;
        if (wr_line_cnt !== LCW'(NL)) begin
            errors++;
            $display("FAIL wr_saturate got=%0d want %0d", wr_line_cnt, NL);
        end
        pulse(1'b0, 1'b1);
        wait_idle("ovr_drain");
        pulse(1'b1, 1'b0);
        checks++;
        if ({overrun, busy} !== 2'b11) begin
            errors++;
            $display("FAIL ovr_sticky ovr_busy=%b want 11", {overrun, busy});
        end
        test_reset();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_cleared got=%b want 0", overrun);
        end
    endtask

    task automatic test_short_frame();
        int r0;
        r0 = n_rise;
        obs_q.delete();
        pulse(1'b1, 1'b0);
        line(1, 1);
        pulse(1'b0, 1'b1);
        exp_q.delete();
        tick();
        checks++;
        if ({busy, rgb_valid, wr_line_cnt} !== {1'b0, 1'b0, LCW'(1)}) begin
            errors++;
            $display("FAIL short state busy=%b rgb=%b wr=%0d want 0 0 1",
                     busy, rgb_valid, wr_line_cnt);
        end
        checks++;
        if (n_rise - r0 !== 0) begin
            errors++;
            $display("FAIL short rgb_rises n=%0d want 0", n_rise - r0);
        end
        checks++;
        if (obs_q.size() !== 0) begin
            errors++;
            $display("FAIL short pix n=%0d want 0", obs_q.size());
        end
    endtask

    task automatic test_simultaneous();
        pulse(1'b1, 1'b0);
        line(1, 0);
        line(1, 0);
        data_valid = 1'b1;
        repeat (LL) tick();
        data_valid  = 1'b0;
        frame_start = 1'b1;
        frame_end   = 1'b1;
        tick();
        frame_start = 1'b0;
        frame_end   = 1'b0;
        checks++;
        if ({rgb_valid, busy, wr_line_cnt} !== {1'b0, 1'b1, LCW'(0)}) begin
            errors++;
            $display("FAIL sim_abort rgb=%b busy=%b wr=%0d want 0 1 0",
                     rgb_valid, busy, wr_line_cnt);
        end
        tick();
        checks++;
        if ({rgb_valid, busy, wr_line_cnt} !== {1'b0, 1'b1, LCW'(0)}) begin
            errors++;
            $display("FAIL sim_prime rgb=%b busy=%b wr=%0d want 0 1 0",
                     rgb_valid, busy, wr_line_cnt);
        end
        pulse(1'b0, 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL sim_end busy=%b want 0", busy);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_frame();
        test_reset_mid_run();
        test_abort();
        test_overrun();
        test_short_frame();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
